// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the ROM/decode address and word widths.
package fetch_pkg;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 14;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/instr_fetch.sv
// PC and fetch register feeding decode: drives the ROM address from the PC and latches the
// returned word with its address, handling stall, redirect, halt and a saturating fetch count.
module instr_fetch #(
  parameter int ADDR_W   = 10,
  parameter int INSTR_W  = 14,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt_req,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);
  import fetch_pkg::*;

  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid;
  logic               w_load_pc;
  logic               w_fetch;
  logic               w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     if (!redirect_valid && halt_req) w_state_nxt = HALT;
      HALT:    if (redirect_valid) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Redirect outranks halt, which outranks stall; BOOT ignores every input.
  always_comb begin
    w_load_pc = 1'b0;
    w_fetch   = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      RUN: begin
        if (redirect_valid) begin
          w_load_pc = 1'b1;
          w_flush   = 1'b1;
        end else if (halt_req) begin
          w_flush   = 1'b1;
        end else if (!stall) begin
          w_fetch   = 1'b1;
        end
      end
      HALT:    w_load_pc = redirect_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_load_pc) begin
        r_pc <= redirect_target;
      end else if (w_fetch) begin
        r_pc <= r_pc + PC_ONE;
      end
      if (w_fetch) begin
        r_instr    <= rom_data;
        r_instr_pc <= r_pc;
      end
      // A flushed slot stays a bubble; instr/instr_pc keep their stale contents.
      if (w_flush) begin
        r_valid <= 1'b0;
      end else if (w_fetch) begin
        r_valid <= 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_fetch_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_fetch),
    .o_count (fetch_count)
  );

  assign rom_addr    = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot latency, free run, stall, redirect, halt, wrap,
// asynchronous reset and counter saturation against a synthetic ROM image.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rom_addr;
  logic [13:0] rom_data;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_target = '0;
  logic        halt_req = 1'b0;
  logic        instr_valid;
  logic [13:0] instr;
  logic [9:0]  instr_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [9:0]  rom_addr4;
  logic [13:0] rom_data4;
  logic        instr_valid4;
  logic [13:0] instr4;
  logic [9:0]  instr_pc4;
  logic        halted4;
  logic [3:0]  fetch_count4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Every address maps to a distinct word.
  function automatic logic [13:0] rom_fn(input logic [9:0] a);
    logic [13:0] v;
    v = {a[3:0], a} ^ 14'h2A5C;
    return v;
  endfunction

  assign rom_data  = rom_fn(rom_addr);
  assign rom_data4 = rom_fn(rom_addr4);

  instr_fetch dut (
    .clk (clk), .rst (rst), .rom_addr (rom_addr), .rom_data (rom_data),
    .stall (stall), .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .halt_req (halt_req), .instr_valid (instr_valid), .instr (instr),
    .instr_pc (instr_pc), .halted (halted), .fetch_count (fetch_count)
  );

  instr_fetch #(.CNT_W(4)) dut4 (
    .clk (clk), .rst (rst), .rom_addr (rom_addr4), .rom_data (rom_data4),
    .stall (1'b0), .redirect_valid (1'b0), .redirect_target (10'd0),
    .halt_req (1'b0), .instr_valid (instr_valid4), .instr (instr4),
    .instr_pc (instr_pc4), .halted (halted4), .fetch_count (fetch_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs one edge past boot with instr_pc=0 valid.
  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (rom_addr !== 10'd0 || instr_valid !== 1'b0 || instr !== 14'd0 || instr_pc !== 10'd0 ||
        halted !== 1'b0 || fetch_count !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_values: addr=%0d vld=%b instr=%h ipc=%0d halted=%b cnt=%0d, want all 0",
               rom_addr, instr_valid, instr, instr_pc, halted, fetch_count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 10'd0) begin
      n_errors++;
      $display("FAIL boot_bubble: vld=%b addr=%0d, want vld=0 addr=0", instr_valid, rom_addr);
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i <= 36; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'(i) || instr !== rom_fn(10'(i))) begin
        n_errors++;
        $display("FAIL free_run[%0d]: vld=%b ipc=%0d instr=%h, want vld=1 ipc=%0d instr=%h",
                 i, instr_valid, instr_pc, instr, i, rom_fn(10'(i)));
      end
    end
    n_checks++;
    if (fetch_count !== 16'd37) begin
      n_errors++;
      $display("FAIL free_run_count: cnt=%0d, want 37", fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'd5 || instr !== rom_fn(10'd5) ||
          rom_addr !== 10'd6 || fetch_count !== 16'd6) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: vld=%b ipc=%0d instr=%h addr=%0d cnt=%0d, want 1/5/%h/6/6",
                 i, instr_valid, instr_pc, instr, rom_addr, fetch_count, rom_fn(10'd5));
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 10'd6 || fetch_count !== 16'd7) begin
      n_errors++;
      $display("FAIL stall_release: vld=%b ipc=%0d cnt=%0d, want 1/6/7", instr_valid, instr_pc, fetch_count);
    end
  endtask

  task automatic test_redirect_stall();
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_target = 10'd2; stall = 1'b1;
    tick();
    n_checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 10'd2 || instr_pc !== 10'd10) begin
      n_errors++;
      $display("FAIL redirect_bubble: vld=%b addr=%0d ipc=%0d, want 0/2/10", instr_valid, rom_addr, instr_pc);
    end
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 10'd2 || instr !== rom_fn(10'd2) || fetch_count !== 16'd12) begin
      n_errors++;
      $display("FAIL redirect_target: vld=%b ipc=%0d instr=%h cnt=%0d, want 1/2/%h/12",
               instr_valid, instr_pc, instr, fetch_count, rom_fn(10'd2));
    end
  endtask

  task automatic test_halt();
    repeat (5) tick();
    halt_req = 1'b1;
    tick();
    n_checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 10'd8) begin
      n_errors++;
      $display("FAIL halt_enter: halted=%b vld=%b addr=%0d, want 1/0/8", halted, instr_valid, rom_addr);
    end
    halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      halt_req = ~i[0];
      tick();
      n_checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 10'd8 || fetch_count !== 16'd17) begin
        n_errors++;
        $display("FAIL halt_hold[%0d]: halted=%b vld=%b addr=%0d cnt=%0d, want 1/0/8/17",
                 i, halted, instr_valid, rom_addr, fetch_count);
      end
    end
    stall = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b1; redirect_target = 10'd0;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || instr_valid !== 1'b0 || rom_addr !== 10'd0) begin
      n_errors++;
      $display("FAIL halt_exit: halted=%b vld=%b addr=%0d, want 0/0/0", halted, instr_valid, rom_addr);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 10'd0 || instr !== rom_fn(10'd0)) begin
      n_errors++;
      $display("FAIL halt_resume: vld=%b ipc=%0d instr=%h, want 1/0/%h", instr_valid, instr_pc, instr, rom_fn(10'd0));
    end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_pc [4];
    exp_pc[0] = 10'd1022; exp_pc[1] = 10'd1023; exp_pc[2] = 10'd0; exp_pc[3] = 10'd1;
    redirect_valid = 1'b1; redirect_target = 10'd1022;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr !== rom_fn(exp_pc[i])) begin
        n_errors++;
        $display("FAIL wrap[%0d]: vld=%b ipc=%0d instr=%h, want 1/%0d/%h",
                 i, instr_valid, instr_pc, instr, exp_pc[i], rom_fn(exp_pc[i]));
      end
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rom_addr !== 10'd0 || instr_valid !== 1'b0 || instr !== 14'd0 || instr_pc !== 10'd0 ||
        halted !== 1'b0 || fetch_count !== 16'd0) begin
      n_errors++;
      $display("FAIL async_reset: addr=%0d vld=%b instr=%h ipc=%0d halted=%b cnt=%0d, want all 0",
               rom_addr, instr_valid, instr, instr_pc, halted, fetch_count);
    end
    stall = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reboot_bubble: vld=%b, want 0", instr_valid);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 10'd0 || fetch_count !== 16'd1) begin
      n_errors++;
      $display("FAIL async_reboot_first: vld=%b ipc=%0d cnt=%0d, want 1/0/1", instr_valid, instr_pc, fetch_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    n_checks++;
    if (fetch_count4 !== 4'd1) begin
      n_errors++;
      $display("FAIL sat_start: cnt=%0d, want 1", fetch_count4);
    end
    repeat (13) tick();
    n_checks++;
    if (fetch_count4 !== 4'd14) begin
      n_errors++;
      $display("FAIL sat_below: cnt=%0d, want 14", fetch_count4);
    end
    tick();
    n_checks++;
    if (fetch_count4 !== 4'd15) begin
      n_errors++;
      $display("FAIL sat_reach: cnt=%0d, want 15", fetch_count4);
    end
    repeat (5) tick();
    n_checks++;
    if (fetch_count4 !== 4'd15 || instr_valid4 !== 1'b1 || instr_pc4 !== 10'd19) begin
      n_errors++;
      $display("FAIL sat_hold: cnt=%0d vld=%b ipc=%0d, want 15/1/19", fetch_count4, instr_valid4, instr_pc4);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
